shift_rr_scheduler: RTL and testbench
=====================================

// Module: shift_rr_scheduler
// PURPOSE
//  Shares one 11-bit logical-right barrel shifter between two requesters
//  (req0 = exponent-alignment path, req1 = normalisation path). Round-robin
//  grant, valid/ready on every port. One-entry registered result stage.
//  Sits between the FP add/sub front end and the rounding stage.
// PARAMETERS
//  DATA_W  11  operand/result width; fixed to the shifter datapath width
//  AMT_W   4   shift-amount width; legal amounts 0..15
//  NREQ    2   number of requesters; fixed at 2 in this revision
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       asynchronous active-low reset
//  req_valid   in   NREQ    per-requester request valid
//  req_ready   out  NREQ    per-requester accept; one-hot or zero
//  req_data    in   NREQ*DATA_W  operands; requester i in bits [i*DATA_W +: DATA_W]
//  req_amt     in   NREQ*AMT_W   shift amounts; same packing
//  rsp_valid   out  1       result register holds a valid result
//  rsp_ready   in   1       downstream accepts the result
//  rsp_id      out  1       index of the requester that owns rsp_data
//  rsp_data    out  DATA_W  registered result = data >> amt (zero fill)
//  rsp_sticky  out  1       OR of shifted-out bits (SHIFT_STICKY_EN only)
// BEHAVIOUR
//  - Reset: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_sticky=0, req_ready=0,
//    last_grant=1, so req0 wins the first contention.
//  - Output FSM: EMPTY -> FULL on accept. FULL -> EMPTY on rsp_ready with no
//    new accept. FULL -> FULL on rsp_ready with a same-cycle accept.
//    FULL holds all rsp_* outputs stable while rsp_ready=0.
//  - can_accept = EMPTY | (FULL & rsp_ready). This gives full throughput:
//    one result per cycle when downstream never stalls.
//  - Grant: only one requester valid -> that requester. Both valid -> the one
//    != last_grant. last_grant updates only on an actual accept.
//  - req_ready[i] = can_accept & grant[i]. It is combinational from
//    req_valid/rsp_ready and depends on no req_ready input.
//  - Transfer on req_valid[i] & req_ready[i]. In that cycle:
//    operand -> shifter; result, id and sticky are registered at the edge.
//  - Latency: accept at edge N, rsp_valid=1 after edge N. No bypass path.
//  - Arithmetic: logical right shift with zero fill. amt >= DATA_W (11..15)
//    gives rsp_data = 0. amt = 0 passes data through unchanged.
//  - Requesters must hold data/amt stable while valid & !ready. The block
//    does not check this.
//  - Reset mid-operation: any in-flight result is discarded. Arbitration
//    pointer returns to its reset value.
// CONFIGURATION
//  SHIFT_STICKY_EN defined: rsp_sticky = |(data & ((1<<amt)-1)).
//    amt >= DATA_W gives rsp_sticky = |data.
//    It is registered alongside rsp_data.
//  SHIFT_STICKY_EN undefined: rsp_sticky port is absent, no sticky logic.
// STRUCTURE
//  - Shared package shift_pkg:
//    - DATA_W and AMT_W localparams
//    - typedef shift_req_t {data, amt}
//    - typedef shift_rsp_t {id, data, sticky}
//    - typedef enum {OUT_EMPTY, OUT_FULL} out_state_e
//  - Sub-module rr_arb2: two-way round-robin arbiter.
//    Inputs req, update, and the last_grant flop; output one-hot grant.
//  - Shifter: instantiates the existing BarrelShifter datapath, selected
//    input muxed by grant.
// TESTING
//  1. Reset: after rst_n release, rsp_valid=0 and req_ready=0 with no
//     requests. Req0 data=11'h7FF, amt=3 -> next cycle rsp_data=11'h0FF,
//     rsp_id=0.
//  2. Contention: both valid every cycle, rsp_ready=1 -> grants alternate
//     0,1,0,1 and one result per cycle. Req1 data=11'h400, amt=10 gives 11'h001.
//  3. Backpressure: rsp_ready=0 for 5 cycles with result FULL -> req_ready=0
//     and rsp_* stable. Release -> same-cycle accept, no bubble.
//  4. Boundary amounts: amt=0 on 11'h555 -> 11'h555. amt=11 and amt=15 on
//     11'h7FF -> 11'h000.
//  5. Sticky (SHIFT_STICKY_EN): 11'h004 amt=2 -> data 11'h001, sticky 0.
//     11'h005 amt=2 -> data 11'h001, sticky 1. 11'h001 amt=12 -> data 0, sticky 1.
//  6. Async reset asserted while FULL with rsp_ready=0 -> rsp_valid drops
//     immediately. After release, contention grants req0 first.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constants for the shift_rr_scheduler block.
// The sticky field exists only when SHIFT_STICKY_EN is defined.
package shift_pkg;

  localparam int DATA_W = 11;
  localparam int AMT_W  = 4;
  localparam int NREQ   = 2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amt;
  } shift_req_t;

  typedef struct packed {
    logic              id;
    logic [DATA_W-1:0] data;
`ifdef SHIFT_STICKY_EN
    logic              sticky;
`endif
  } shift_rsp_t;

  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_state_e;

`ifdef SHIFT_STICKY_EN
  // Ones in the bit positions that a right shift by amt discards; all ones once amt >= DATA_W.
  function automatic logic [DATA_W-1:0] low_mask(input logic [AMT_W-1:0] amt);
    return ~({DATA_W{1'b1}} << amt);
  endfunction
`endif

endpackage

// File: rtl/barrel_shifter.sv
// Logical-right barrel shifter datapath with zero fill.
// Amounts of DATA_W or more yield zero.
module BarrelShifter #(
  parameter int DATA_W = 11,
  parameter int AMT_W  = 4
) (
  input  logic [DATA_W-1:0] data_in,
  input  logic [AMT_W-1:0]  amt,
  output logic [DATA_W-1:0] data_out
);

  assign data_out = data_in >> amt;

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; last_grant resets to 1 so requester 0 wins
// the first contention. The pointer only moves when update marks a transfer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_grant;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/shift_rr_scheduler.sv
// Shares one barrel shifter between two valid/ready requesters with a
// one-entry registered result stage. Optional sticky output: SHIFT_STICKY_EN.
module shift_rr_scheduler
  import shift_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic [NREQ*AMT_W-1:0]  req_amt,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [DATA_W-1:0]      rsp_data
`ifdef SHIFT_STICKY_EN
  ,
  output logic                   rsp_sticky
`endif
);

  shift_req_t        req [NREQ];
  shift_req_t        sel;
  shift_rsp_t        rsp_d;
  shift_rsp_t        rsp_q;
  out_state_e        state;
  out_state_e        state_next;
  logic [NREQ-1:0]   grant;
  logic              can_accept;
  logic              accept;
  logic [DATA_W-1:0] shifted;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req[i].data = req_data[i*DATA_W +: DATA_W];
      req[i].amt  = req_amt[i*AMT_W +: AMT_W];
    end
  end

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .update (accept),
    .grant  (grant)
  );

  // A full register can still take a new result when it drains in the same cycle.
  assign can_accept = (state == OUT_EMPTY) || rsp_ready;
  assign req_ready  = grant & {NREQ{can_accept}};
  assign accept     = |(req_valid & req_ready);
  assign sel        = grant[1] ? req[1] : req[0];

  BarrelShifter #(
    .DATA_W (DATA_W),
    .AMT_W  (AMT_W)
  ) u_shifter (
    .data_in  (sel.data),
    .amt      (sel.amt),
    .data_out (shifted)
  );

  always_comb begin
    rsp_d.id   = grant[1];
    rsp_d.data = shifted;
`ifdef SHIFT_STICKY_EN
    rsp_d.sticky = |(sel.data & low_mask(sel.amt));
`endif
  end

  always_comb begin
    state_next = state;
    unique case (state)
      OUT_EMPTY: if (accept) state_next = OUT_FULL;
      OUT_FULL:  if (rsp_ready && !accept) state_next = OUT_EMPTY;
      default:   state_next = OUT_EMPTY;
    endcase
  end

  // NOTE: the result register is reset so an in-flight result is discarded, not just hidden.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OUT_EMPTY;
      rsp_q <= '0;
    end else begin
      state <= state_next;
      if (accept) rsp_q <= rsp_d;
    end
  end

  assign rsp_valid = (state == OUT_FULL);
  assign rsp_id    = rsp_q.id;
  assign rsp_data  = rsp_q.data;
`ifdef SHIFT_STICKY_EN
  assign rsp_sticky = rsp_q.sticky;
`endif

endmodule

// File: tb/tb_shift_rr_scheduler.sv
// Directed self-checking bench for shift_rr_scheduler; sticky checks run only
// when SHIFT_STICKY_EN is defined.
module tb_shift_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [21:0] req_data = '0;
  logic [7:0]  req_amt = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_id;
  logic [10:0] rsp_data;
`ifdef SHIFT_STICKY_EN
  logic        rsp_sticky;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_rr_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
`ifdef SHIFT_STICKY_EN
    ,
    .rsp_sticky(rsp_sticky)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [10:0] d, input logic [3:0] a);
    if (idx == 0) begin
      req_data[10:0] = d;
      req_amt[3:0]   = a;
    end else begin
      req_data[21:11] = d;
      req_amt[7:4]    = a;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    #12 rst_n = 1'b1;
    step();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
    tests++; if (rsp_data !== 11'h000) begin fails++; $display("FAIL reset_rsp_data got %h want 000", rsp_data); end
    tests++; if (rsp_id !== 1'b0) begin fails++; $display("FAIL reset_rsp_id got %b want 0", rsp_id); end
    set_req(0, 11'h7FF, 4'd3); req_valid = 2'b01;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL first_req_ready got %b want 01", req_ready); end
    step();
    req_valid = 2'b00;
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL first_rsp_valid got %b want 1", rsp_valid); end
    tests++; if (rsp_data !== 11'h0FF) begin fails++; $display("FAIL first_rsp_data got %h want 0ff", rsp_data); end
    tests++; if (rsp_id !== 1'b0) begin fails++; $display("FAIL first_rsp_id got %b want 0", rsp_id); end
    rsp_ready = 1'b1;
    step();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL drain_rsp_valid got %b want 0", rsp_valid); end
  endtask

  // After test_reset the last accepted requester was 0, so requester 1 is granted first.
  logic exp_gnt;

  task automatic test_contention();
    logic [10:0] exp_data;
    exp_gnt = 1'b1;
    set_req(0, 11'h7FF, 4'd3);
    set_req(1, 11'h400, 4'd10);
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (req_ready !== (exp_gnt ? 2'b10 : 2'b01)) begin fails++; $display("FAIL cont_req_ready[%0d] got %b want gnt %b", i, req_ready, exp_gnt); end
      step();
      exp_data = exp_gnt ? 11'h001 : 11'h0FF;
      tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL cont_rsp_valid[%0d] got %b want 1", i, rsp_valid); end
      tests++; if (rsp_id !== exp_gnt) begin fails++; $display("FAIL cont_rsp_id[%0d] got %b want %b", i, rsp_id, exp_gnt); end
      tests++; if (rsp_data !== exp_data) begin fails++; $display("FAIL cont_rsp_data[%0d] got %h want %h", i, rsp_data, exp_data); end
      exp_gnt = ~exp_gnt;
    end
  endtask

  task automatic test_backpressure();
    logic        held_id;
    logic [10:0] held_data;
    // Result of the last contention accept is in the register; both still request.
    held_id   = ~exp_gnt;
    held_data = held_id ? 11'h001 : 11'h0FF;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL bp_req_ready[%0d] got %b want 00", i, req_ready); end
      step();
      tests++; if (rsp_valid !== 1'b1 || rsp_id !== held_id || rsp_data !== held_data) begin
        fails++; $display("FAIL bp_hold[%0d] got v%b id%b %h want v1 id%b %h", i, rsp_valid, rsp_id, rsp_data, held_id, held_data);
      end
    end
    rsp_ready = 1'b1;
    #1;
    tests++; if (req_ready !== (exp_gnt ? 2'b10 : 2'b01)) begin fails++; $display("FAIL bp_release_ready got %b want gnt %b", req_ready, exp_gnt); end
    step();
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== exp_gnt) begin fails++; $display("FAIL bp_release_rsp got v%b id%b want v1 id%b", rsp_valid, rsp_id, exp_gnt); end
    req_valid = 2'b00;
    step();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %b want 0", rsp_valid); end
  endtask

  task automatic test_boundary();
    logic [10:0] vd [5] = '{11'h555, 11'h7FF, 11'h7FF, 11'h7FF, 11'h6A5};
    logic [3:0]  va [5] = '{4'd0,    4'd11,   4'd15,   4'd1,    4'd4};
    logic [10:0] ve [5] = '{11'h555, 11'h000, 11'h000, 11'h3FF, 11'h06A};
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_req(i % 2, vd[i], va[i]);
      req_valid = (i % 2 == 0) ? 2'b01 : 2'b10;
      step();
      tests++; if (rsp_valid !== 1'b1 || rsp_data !== ve[i] || rsp_id !== 1'(i % 2)) begin
        fails++; $display("FAIL bound[%0d] got v%b id%b %h want v1 id%0d %h", i, rsp_valid, rsp_id, rsp_data, i % 2, ve[i]);
      end
    end
    req_valid = 2'b00;
    step();
  endtask

`ifdef SHIFT_STICKY_EN
  task automatic test_sticky();
    logic [10:0] vd [4] = '{11'h004, 11'h005, 11'h001, 11'h000};
    logic [3:0]  va [4] = '{4'd2,    4'd2,    4'd12,   4'd0};
    logic [10:0] ve [4] = '{11'h001, 11'h001, 11'h000, 11'h000};
    logic        vs [4] = '{1'b0,    1'b1,    1'b1,    1'b0};
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(0, vd[i], va[i]);
      req_valid = 2'b01;
      step();
      tests++; if (rsp_data !== ve[i] || rsp_sticky !== vs[i]) begin
        fails++; $display("FAIL sticky[%0d] got %h s%b want %h s%b", i, rsp_data, rsp_sticky, ve[i], vs[i]);
      end
    end
    req_valid = 2'b00;
    step();
  endtask
`endif

  task automatic test_async_reset();
    // Leave the pointer favouring requester 1 (last grant 0) before resetting while FULL.
    rsp_ready = 1'b0;
    set_req(0, 11'h7FF, 4'd0);
    set_req(1, 11'h400, 4'd10);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL ar_full got %b want 1", rsp_valid); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (rsp_valid !== 1'b0 || rsp_data !== 11'h000) begin fails++; $display("FAIL ar_drop got v%b %h want v0 000", rsp_valid, rsp_data); end
    #3 rst_n = 1'b1;
    step();
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL ar_first_grant got %b want 01", req_ready); end
    step();
    req_valid = 2'b00;
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 11'h7FF) begin
      fails++; $display("FAIL ar_first_rsp got v%b id%b %h want v1 id0 7ff", rsp_valid, rsp_id, rsp_data);
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_backpressure();
    test_boundary();
`ifdef SHIFT_STICKY_EN
    test_sticky();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
